apb_fll_cfg_master: RTL and testbench

//  APB slave that initiates transfers on the FLL configuration port: the fll_req/fll_wrn/fll_add/fll_data/fll_ack/fll_r_data

---
 rtl/apb_fll_cfg_master_if.sv | 25 ++
 rtl/apb_fll_cfg_master.sv | 172 +++++++++++++++++
 tb/tb_apb_fll_cfg_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_fll_cfg_master_if.sv
// APB bus bundle for apb_fll_cfg_master.
//   master modport: drives PADDR/PSEL/PENABLE/PWRITE/PWDATA, samples PRDATA/PREADY/PSLVERR
//   slave  modport: the reverse direction, used by the FLL config master
interface apb_fll_cfg_master_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [31:0]               PWDATA;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_fll_cfg_master.sv
// APB slave that bridges bus accesses onto the FLL configuration port
// (4-phase req/ack handshake towards clk_rst_gen).
//   clk_i, rst_i     : clock, synchronous active-high reset
//   apb (slave)      : APB bus; 0x0..0xC -> FLL regs 0..3, 0x10 -> STATUS
//                      {30'b0, tmo_flag, lock_sync}, anything else -> PSLVERR
//   fll_req_o        : registered request, high only while waiting for ack
//   fll_wrn_o        : 0 = write, 1 = read
//   fll_add_o        : FLL register index
//   fll_data_o       : FLL write data
//   fll_ack_i        : acknowledge (may be combinational from fll_req_o)
//   fll_r_data_i     : read data, valid while ack is high
//   fll_lock_i       : asynchronous FLL lock, synchronised internally
module apb_fll_cfg_master #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    apb_fll_cfg_master_if.slave apb,
    output logic                fll_req_o,
    output logic                fll_wrn_o,
    output logic [1:0]          fll_add_o,
    output logic [31:0]         fll_data_o,
    input  logic                fll_ack_i,
    input  logic [31:0]         fll_r_data_i,
    input  logic                fll_lock_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic               wrn_q, wrn_d;
    logic [1:0]         add_q, add_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        prdata_q, prdata_d;
    logic               err_q, err_d;
    logic               tmo_flag_q, tmo_flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lock_meta_q, lock_sync_q;

    logic               addr_hi_zero;
    logic               is_fll;
    logic               is_status;
    logic               unused_paddr;

    // Byte-lane bits are don't-care; anything above bit 4 must be zero.
    assign addr_hi_zero = ((apb.PADDR >> 5) == '0);
    assign is_fll       = addr_hi_zero & ~apb.PADDR[4];
    assign is_status    = addr_hi_zero & (apb.PADDR[4:2] == 3'b100);
    assign unused_paddr = ^apb.PADDR[1:0];

    always_comb begin
        state_d    = state_q;
        wrn_d      = wrn_q;
        add_d      = add_q;
        data_d     = data_q;
        prdata_d   = prdata_q;
        err_d      = err_q;
        tmo_flag_d = tmo_flag_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (apb.PSEL && apb.PENABLE) begin
                    prdata_d = '0;
                    if (is_fll) begin
                        add_d   = apb.PADDR[3:2];
                        wrn_d   = ~apb.PWRITE;
                        data_d  = apb.PWDATA;
                        cnt_d   = '0;
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                        if (is_status) begin
                            if (!apb.PWRITE) begin
                                prdata_d = {30'b0, tmo_flag_q, lock_sync_q};
                            end else if (apb.PWDATA[1]) begin
                                tmo_flag_d = 1'b0;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            REQ: begin
                if (fll_ack_i) begin
                    if (wrn_q) begin
                        prdata_d = fll_r_data_i;
                    end
                    cnt_d   = '0;
                    state_d = REL;
                end else if (cnt_q == CNT_MAX) begin
                    tmo_flag_d = 1'b1;
                    err_d      = 1'b1;
                    prdata_d   = '0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REL: begin
                if (!fll_ack_i) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    // A read whose ack never falls is reported as failed, so
                    // the data captured on the rising ack is discarded.
                    tmo_flag_d = 1'b1;
                    err_d      = 1'b1;
                    prdata_d   = '0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered request: asserted exactly for the cycles spent in REQ.
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            wrn_q       <= 1'b1;
            add_q       <= '0;
            data_q      <= '0;
            prdata_q    <= '0;
            err_q       <= 1'b0;
            tmo_flag_q  <= 1'b0;
            cnt_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wrn_q       <= wrn_d;
            add_q       <= add_d;
            data_q      <= data_d;
            prdata_q    <= prdata_d;
            err_q       <= err_d;
            tmo_flag_q  <= tmo_flag_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= fll_lock_i;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign fll_req_o   = req_q;
    assign fll_wrn_o   = wrn_q;
    assign fll_add_o   = add_q;
    assign fll_data_o  = data_q;
    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = (state_q == DONE);
    assign apb.PSLVERR = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_apb_fll_cfg_master.sv
// Directed testbench for apb_fll_cfg_master (TIMEOUT_CYCLES = 8).
module tb_apb_fll_cfg_master;

    logic        clk;
    logic        rst;
    logic        fll_req;
    logic        fll_wrn;
    logic [1:0]  fll_add;
    logic [31:0] fll_data;
    logic        fll_ack;
    logic [31:0] fll_r_data;
    logic        fll_lock;

    logic        ack_loop;   // 1: ack = req loopback, 0: ack = ack_man
    logic        ack_man;

    int n_cmp;
    int n_err;

    apb_fll_cfg_master_if #(.APB_ADDR_WIDTH(12)) apb_if ();

    apb_fll_cfg_master #(
        .APB_ADDR_WIDTH(12),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .apb          (apb_if),
        .fll_req_o    (fll_req),
        .fll_wrn_o    (fll_wrn),
        .fll_add_o    (fll_add),
        .fll_data_o   (fll_data),
        .fll_ack_i    (fll_ack),
        .fll_r_data_i (fll_r_data),
        .fll_lock_i   (fll_lock)
    );

    assign fll_ack    = ack_loop ? fll_req : ack_man;
    assign fll_r_data = fll_ack ? 32'h1234_5678 : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Performs one APB transfer; waits = cycles after the access phase until
    // PREADY (-1 if it never came), req_hi = cycles fll_req was seen high.
    task automatic apb_access(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output int waits,
                              output int req_hi, output logic [1:0] add, output logic wrn,
                              output logic [31:0] data);
        bit got;
        @(negedge clk);
        apb_if.PADDR   = addr;
        apb_if.PWRITE  = wr;
        apb_if.PWDATA  = wdata;
        apb_if.PSEL    = 1'b1;
        apb_if.PENABLE = 1'b0;
        @(negedge clk);
        apb_if.PENABLE = 1'b1;
        waits = 0; req_hi = 0; rdata = '0; err = 1'b0; add = '0; wrn = 1'b0; data = '0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            waits++;
            if (fll_req === 1'b1) begin
                req_hi++;
                add  = fll_add;
                wrn  = fll_wrn;
                data = fll_data;
            end
            if (apb_if.PREADY === 1'b1) begin
                rdata = apb_if.PRDATA;
                err   = apb_if.PSLVERR;
                got   = 1'b1;
                break;
            end
        end
        apb_if.PSEL    = 1'b0;
        apb_if.PENABLE = 1'b0;
        if (!got) waits = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (apb_if.PRDATA !== 32'h0) begin n_err++; $display("FAIL reset_prdata got %h want 0", apb_if.PRDATA); end
        n_cmp++; if (apb_if.PREADY !== 1'b0) begin n_err++; $display("FAIL reset_pready got %b want 0", apb_if.PREADY); end
        n_cmp++; if (apb_if.PSLVERR !== 1'b0) begin n_err++; $display("FAIL reset_pslverr got %b want 0", apb_if.PSLVERR); end
        n_cmp++; if (fll_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", fll_req); end
        n_cmp++; if (fll_wrn !== 1'b1) begin n_err++; $display("FAIL reset_wrn got %b want 1", fll_wrn); end
        n_cmp++; if (fll_add !== 2'd0) begin n_err++; $display("FAIL reset_add got %0d want 0", fll_add); end
        n_cmp++; if (fll_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", fll_data); end
        rst = 1'b0;
    endtask

    task automatic test_loopback_write();
        logic [31:0] rd, dt; logic er, wn; logic [1:0] ad; int w, rh;
        ack_loop = 1'b1;
        apb_access(12'h008, 1'b1, 32'h0000_ABCD, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (w !== 3) begin n_err++; $display("FAIL wr_latency got %0d want 3", w); end
        n_cmp++; if (rh !== 1) begin n_err++; $display("FAIL wr_req_cycles got %0d want 1", rh); end
        n_cmp++; if (ad !== 2'd2) begin n_err++; $display("FAIL wr_add got %0d want 2", ad); end
        n_cmp++; if (wn !== 1'b0) begin n_err++; $display("FAIL wr_wrn got %b want 0", wn); end
        n_cmp++; if (dt !== 32'h0000_ABCD) begin n_err++; $display("FAIL wr_data got %h want 0000abcd", dt); end
        n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL wr_pslverr got %b want 0", er); end
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL wr_prdata got %h want 0", rd); end
        @(negedge clk);
        n_cmp++; if (apb_if.PREADY !== 1'b0) begin n_err++; $display("FAIL wr_pready_pulse got %b want 0", apb_if.PREADY); end
    endtask

    task automatic test_loopback_read();
        logic [31:0] rd, dt; logic er, wn; logic [1:0] ad; int w, rh;
        ack_loop = 1'b1;
        apb_access(12'h00C, 1'b0, 32'h0, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (w !== 3) begin n_err++; $display("FAIL rd_latency got %0d want 3", w); end
        n_cmp++; if (ad !== 2'd3) begin n_err++; $display("FAIL rd_add got %0d want 3", ad); end
        n_cmp++; if (wn !== 1'b1) begin n_err++; $display("FAIL rd_wrn got %b want 1", wn); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL rd_prdata got %h want 12345678", rd); end
        n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL rd_pslverr got %b want 0", er); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd, dt; logic er, wn; logic [1:0] ad; int w, rh;
        ack_loop = 1'b0; ack_man = 1'b0;
        apb_access(12'h004, 1'b1, 32'h5555_AAAA, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (rh !== 8) begin n_err++; $display("FAIL tmo_req_cycles got %0d want 8", rh); end
        n_cmp++; if (w !== 9) begin n_err++; $display("FAIL tmo_latency got %0d want 9", w); end
        n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL tmo_pslverr got %b want 1", er); end
        n_cmp++; if (fll_req !== 1'b0) begin n_err++; $display("FAIL tmo_req_dropped got %b want 0", fll_req); end
        apb_access(12'h010, 1'b0, 32'h0, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL tmo_status got %h want 2", rd); end
        n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL tmo_status_err got %b want 0", er); end
        apb_access(12'h010, 1'b1, 32'h2, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (w !== 1) begin n_err++; $display("FAIL tmo_clear_latency got %0d want 1", w); end
        apb_access(12'h010, 1'b0, 32'h0, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL tmo_status_cleared got %h want 0", rd); end
    endtask

    task automatic ack_delayed(output int bad);
        int n;
        bad = 0; n = 0;
        while (fll_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) bad++;
        repeat (5) begin @(negedge clk); if (fll_req !== 1'b1) bad++; end
        ack_man = 1'b1;
        @(negedge clk); if (fll_req !== 1'b0) bad++;
        repeat (3) begin @(negedge clk); if (fll_req !== 1'b0) bad++; end
        ack_man = 1'b0;
    endtask

    task automatic test_delayed_ack();
        logic [31:0] rd, dt; logic er, wn; logic [1:0] ad; int w, rh, bad;
        ack_loop = 1'b0; ack_man = 1'b0;
        fork
            apb_access(12'h000, 1'b1, 32'hCAFE_0001, rd, er, w, rh, ad, wn, dt);
            ack_delayed(bad);
        join
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL dly_req_shape got %0d bad cycles want 0", bad); end
        n_cmp++; if (rh !== 6) begin n_err++; $display("FAIL dly_req_cycles got %0d want 6", rh); end
        n_cmp++; if (w !== 11) begin n_err++; $display("FAIL dly_latency got %0d want 11", w); end
        n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL dly_pslverr got %b want 0", er); end
        n_cmp++; if (dt !== 32'hCAFE_0001) begin n_err++; $display("FAIL dly_data got %h want cafe0001", dt); end
        @(negedge clk);
        n_cmp++; if (apb_if.PREADY !== 1'b0) begin n_err++; $display("FAIL dly_pready_pulse got %b want 0", apb_if.PREADY); end
    endtask

    task automatic test_lock_status();
        logic [31:0] rd, dt; logic er, wn; logic [1:0] ad; int w, rh;
        ack_loop = 1'b1;
        #3 fll_lock = 1'b1;
        repeat (3) @(negedge clk);
        apb_access(12'h010, 1'b0, 32'h0, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL lock_status got %h want 1", rd); end
        n_cmp++; if (w !== 1) begin n_err++; $display("FAIL lock_latency got %0d want 1", w); end
        n_cmp++; if (rh !== 0) begin n_err++; $display("FAIL lock_no_req got %0d want 0", rh); end
    endtask

    task automatic test_invalid();
        logic [31:0] rd, dt; logic er, wn; logic [1:0] ad; int w, rh;
        ack_loop = 1'b1;
        apb_access(12'h020, 1'b0, 32'h0, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL inv20_pslverr got %b want 1", er); end
        n_cmp++; if (rh !== 0) begin n_err++; $display("FAIL inv20_no_req got %0d want 0", rh); end
        n_cmp++; if (w !== 1) begin n_err++; $display("FAIL inv20_latency got %0d want 1", w); end
        apb_access(12'h014, 1'b1, 32'h2, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL inv14_pslverr got %b want 1", er); end
        // Error must not persist into the next legal transfer.
        apb_access(12'h000, 1'b1, 32'h1, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL inv_err_cleared got %b want 0", er); end
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] rd, dt; logic er, wn; logic [1:0] ad; int w, rh;
        ack_loop = 1'b0; ack_man = 1'b0;
        @(negedge clk);
        apb_if.PADDR = 12'h004; apb_if.PWRITE = 1'b1; apb_if.PWDATA = 32'h0BAD_F00D;
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0;
        @(negedge clk);
        apb_if.PENABLE = 1'b1;
        @(negedge clk);
        n_cmp++; if (fll_req !== 1'b1) begin n_err++; $display("FAIL rstmid_req_before got %b want 1", fll_req); end
        rst = 1'b1; ack_man = 1'b1;
        @(negedge clk);
        n_cmp++; if (fll_req !== 1'b0) begin n_err++; $display("FAIL rstmid_req_dropped got %b want 0", fll_req); end
        n_cmp++; if (fll_data !== 32'h0) begin n_err++; $display("FAIL rstmid_data got %h want 0", fll_data); end
        n_cmp++; if (fll_wrn !== 1'b1) begin n_err++; $display("FAIL rstmid_wrn got %b want 1", fll_wrn); end
        rst = 1'b0; apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (fll_req !== 1'b0 || apb_if.PREADY !== 1'b0) begin n_err++; $display("FAIL rstmid_ack_ignored got req=%b pready=%b want 0/0", fll_req, apb_if.PREADY); end
        ack_man = 1'b0; ack_loop = 1'b1;
        apb_access(12'h008, 1'b1, 32'h0000_0077, rd, er, w, rh, ad, wn, dt);
        n_cmp++; if (w !== 3 || er !== 1'b0) begin n_err++; $display("FAIL rstmid_next_xfer got waits=%0d err=%b want 3/0", w, er); end
        n_cmp++; if (dt !== 32'h77 || ad !== 2'd2) begin n_err++; $display("FAIL rstmid_next_fields got data=%h add=%0d want 77/2", dt, ad); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; ack_loop = 1'b1; ack_man = 1'b0; fll_lock = 1'b0;
        apb_if.PADDR = '0; apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
        apb_if.PWRITE = 1'b0; apb_if.PWDATA = '0;
        test_reset();
        test_loopback_write();
        test_loopback_read();
        test_timeout();
        test_delayed_ack();
        test_lock_status();
        test_invalid();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
